spectrum_buf_ctrl: RTL and testbench
====================================

# spectrum_buf_ctrl

Ping-pong buffer controller between the FFT magnitude stream and the spectrum pattern generator on the HDMI path. It captures one complete FFT frame into the write bank and swaps banks only at a video frame boundary, so the display never shows a torn spectrum. It also serves the renderer's per-bin `data_req` / `fft_point_done` handshake by sequencing `fft_point_cnt` and presenting the scaled, clamped magnitude on `fft_data`.

## Interface
Parameters:
- `FFT_POINT`, 256: points per FFT frame; power of two.
- `ADDR_BITS`, 8: log2(`FFT_POINT`).
- `DATA_BITS`, 32: magnitude width.
- `V_ACT`, 720: active lines; clamp ceiling is `V_ACT`-1.
- `SCALE_SHIFT`, 0: right shift applied to the stored magnitude before clamping.

Ports:
- `pix_clk`  in  1  sole clock; the FFT stream is already in this domain.
- `rst`  in  1  synchronous, active-high reset.
- `fft_valid`  in  1  magnitude sample valid.
- `fft_last`  in  1  marks the last sample of an FFT frame.
- `fft_mag`  in  DATA_BITS  magnitude sample.
- `fft_ready`  out  1  controller can accept a sample.
- `vs_in`  in  1  vertical sync from the timing generator, active-high.
- `data_req`  in  1  renderer pulse requesting the next bin.
- `fft_point_done`  in  1  renderer pulse at the end of an active line.
- `fft_point_cnt`  out  ADDR_BITS  current display bin index.
- `fft_data`  out  DATA_BITS  scaled and clamped magnitude of `fft_point_cnt`.
- `frame_swap`  out  1  one-cycle pulse when banks swap.
- `frame_err`  out  1  one-cycle pulse when an FFT frame is malformed and dropped.

## Operation
- Storage is a 2×`FFT_POINT` simple dual-port RAM.
  - Write address is {`wr_bank`, `wr_idx`}.
  - Read address is {~`wr_bank`, `fft_point_cnt`}.
- Write FSM states:
  - **FILL**:
    - `fft_ready`=1.
    - An accepted sample (`fft_valid`&&`fft_ready`) is written and `wr_idx` increments.
    - `fft_last` with `wr_idx`==`FFT_POINT`-1 → go to FULL.
    - `fft_last` at any other index → `frame_err` pulse, `wr_idx`←0, stay in FILL.
    - A sample at `wr_idx`==`FFT_POINT`-1 without `fft_last` → `frame_err` pulse, `wr_idx`←0, stay in FILL.
  - **FULL**:
    - `fft_ready`=0; the write bank is held.
    - On a swap event → toggle `wr_bank`, `wr_idx`←0, set `disp_valid`=1, pulse `frame_swap`, go to FILL.
- Swap event: rising edge of `vs_in`, detected from a registered copy of `vs_in`. A `vs_in` edge while in FILL causes no swap; the display keeps the old bank.
- Read sequencer:
  - `fft_point_cnt`←0 on `fft_point_done` or a `vs_in` rising edge.
  - Otherwise `fft_point_cnt` increments on `data_req`, saturating at `FFT_POINT`-1.
  - If `fft_point_done` and `data_req` arrive together, `fft_point_done` wins: count goes to 0.
- Output arithmetic:
  - s = RAM_q >> `SCALE_SHIFT`.
  - `fft_data` = (s > `V_ACT`-1) ? `V_ACT`-1 : s, registered.
  - `fft_data` is forced to 0 while `disp_valid`=0, i.e. before the first swap. The RAM is not reset.

## Timing
- Reset values:
  - `fft_point_cnt`=0, `fft_data`=0, `fft_ready`=0 during reset and 1 the cycle after.
  - `frame_swap`=0, `frame_err`=0.
  - FSM=FILL, `wr_bank`=0, `wr_idx`=0, `disp_valid`=0.
- Reset mid-frame discards the partial write.
- The write is committed in the same cycle the sample is accepted.
- The FULL transition is registered: `fft_ready` drops the cycle after the `fft_last` acceptance.
- `frame_swap` is asserted the cycle after the `vs_in` rising edge is sampled.
- Read latency: `fft_point_cnt` change → `fft_data` valid 2 cycles later (RAM read plus output register). The renderer's bin width of ≥5 pixels absorbs this.
- A swap and a `data_req` in the same cycle are legal. The count follows the vsync-edge reset (→0) and the new bank is read from that cycle on.

## Structure
- A shared package holds:
  - the write FSM state encoding (FILL, FULL);
  - the `FFT_POINT`/`ADDR_BITS` relationship constant;
  - the `V_ACT` clamp constant, shared with the pattern generator.
- One sub-module, `spectrum_dpram`: parameterised simple dual-port RAM with 1-cycle registered read, inferred block RAM, no reset on the array.
- The FSM, read counter, vsync edge detector and clamp stay in the top module.

## Test plan
- **Clean frame and swap:** after reset, stream 256 samples of value = index with `fft_last` on #255, then pulse `vs_in`.
  - Required: `fft_ready` falls after #255.
  - Required: `frame_swap` is a one-cycle pulse.
  - Then 10 `data_req` pulses → `fft_point_cnt`=10, and `fft_data`=10 two cycles later.
- **Pre-swap blanking:** after reset, issue `data_req` pulses with no swap → `fft_data` stays 0.
- **Malformed frames:**
  - `fft_last` on sample #100 → `frame_err` pulse, `wr_idx`=0, no FULL.
  - A following 256-sample frame is accepted normally.
- **Clamp and scale:** `SCALE_SHIFT`=2, sample value 4000 → `fft_data`=719; sample value 400 → `fft_data`=100.
- **Handshake corners:**
  - Simultaneous `data_req` and `fft_point_done` → count 0.
  - 300 `data_req` pulses → count saturates at 255.
  - `vs_in` edge while in FILL → no `frame_swap`, old data still displayed.
- **Reset mid-operation:** assert `rst` after 128 samples → all outputs at reset values; the next full frame plus vsync swaps into bank 1 correctly.

Source files
------------

// File: rtl/spectrum_buf_ctrl_pkg.sv
// Shared constants and types for the spectrum ping-pong buffer path.
// The pattern generator imports V_ACT_DEF so both sides clamp to the same ceiling.
package spectrum_buf_ctrl_pkg;

  // Write-side bank state: FILL accepts samples, FULL holds until vsync.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;

  localparam int FFT_POINT_DEF = 256;
  localparam int ADDR_BITS_DEF = $clog2(FFT_POINT_DEF);
  localparam int V_ACT_DEF     = 720;

endpackage

// File: rtl/spectrum_buf_ctrl_if.sv
// FFT magnitude stream plus renderer handshake, bundled for the buffer controller.
interface spectrum_buf_ctrl_if
  import spectrum_buf_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = 32
);
  logic                 fft_valid;
  logic                 fft_last;
  logic [DATA_BITS-1:0] fft_mag;
  logic                 fft_ready;
  logic                 vs_in;
  logic                 data_req;
  logic                 fft_point_done;
  logic [ADDR_BITS-1:0] fft_point_cnt;
  logic [DATA_BITS-1:0] fft_data;
  logic                 frame_swap;
  logic                 frame_err;

  modport master (
    output fft_valid, fft_last, fft_mag, vs_in, data_req, fft_point_done,
    input  fft_ready, fft_point_cnt, fft_data, frame_swap, frame_err
  );

  modport slave (
    input  fft_valid, fft_last, fft_mag, vs_in, data_req, fft_point_done,
    output fft_ready, fft_point_cnt, fft_data, frame_swap, frame_err
  );
endinterface

// File: rtl/spectrum_buf_ctrl_dpram.sv
// Simple dual-port RAM, one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module spectrum_dpram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              pix_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write-first is irrelevant here: read and write always target opposite banks.
  always_ff @(posedge pix_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/spectrum_buf_ctrl.sv
// Ping-pong buffer between the FFT magnitude stream and the spectrum renderer.
// A complete FFT frame is captured into the write bank; banks swap only on a
// vsync rising edge so the displayed spectrum is never torn.
module spectrum_buf_ctrl
  import spectrum_buf_ctrl_pkg::*;
#(
  parameter int FFT_POINT   = FFT_POINT_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int DATA_BITS   = 32,
  parameter int V_ACT       = V_ACT_DEF,
  parameter int SCALE_SHIFT = 0
) (
  input  logic              pix_clk,
  input  logic              rst,
  spectrum_buf_ctrl_if.slave bus
);
  localparam logic [ADDR_BITS-1:0] IDX_MAX = ADDR_BITS'(FFT_POINT - 1);
  localparam logic [DATA_BITS-1:0] CLAMP   = DATA_BITS'(V_ACT - 1);

  wr_state_t            state, state_nxt;
  logic                 wr_bank, wr_bank_nxt;
  logic [ADDR_BITS-1:0] wr_idx, wr_idx_nxt;
  logic                 disp_valid, disp_valid_nxt;
  logic                 swap_nxt, err_nxt;
  logic                 rdy_q, swap_q, err_q, vs_q;
  logic                 vs_rise, accept;
  logic [ADDR_BITS-1:0] rd_cnt;
  logic [1:0]           vld_pipe;
  logic [DATA_BITS-1:0] ram_q, scaled, data_q;

  assign vs_rise = bus.vs_in & ~vs_q;
  assign accept  = bus.fft_valid & rdy_q;

  // Write FSM: frame framing checks in FILL, hold-and-swap in FULL.
  always_comb begin
    state_nxt      = state;
    wr_bank_nxt    = wr_bank;
    wr_idx_nxt     = wr_idx;
    disp_valid_nxt = disp_valid;
    swap_nxt       = 1'b0;
    err_nxt        = 1'b0;
    case (state)
      FILL: if (accept) begin
        if (bus.fft_last && wr_idx == IDX_MAX) begin
          state_nxt = FULL;
        end else if (bus.fft_last || wr_idx == IDX_MAX) begin
          // Short or over-long frame: drop it and restart at bin 0.
          err_nxt    = 1'b1;
          wr_idx_nxt = '0;
        end else begin
          wr_idx_nxt = wr_idx + 1'b1;
        end
      end
      FULL: if (vs_rise) begin
        wr_bank_nxt    = ~wr_bank;
        wr_idx_nxt     = '0;
        disp_valid_nxt = 1'b1;
        swap_nxt       = 1'b1;
        state_nxt      = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Write-side state registers; ready is registered so it is low throughout reset.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state      <= FILL;
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      disp_valid <= 1'b0;
      rdy_q      <= 1'b0;
      swap_q     <= 1'b0;
      err_q      <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_bank    <= wr_bank_nxt;
      wr_idx     <= wr_idx_nxt;
      disp_valid <= disp_valid_nxt;
      rdy_q      <= (state_nxt == FILL);
      swap_q     <= swap_nxt;
      err_q      <= err_nxt;
      vs_q       <= bus.vs_in;
    end
  end

  // Display bin counter: line end or vsync restarts, data_req advances and saturates.
  always_ff @(posedge pix_clk) begin
    if (rst)                                   rd_cnt <= '0;
    else if (bus.fft_point_done || vs_rise)    rd_cnt <= '0;
    else if (bus.data_req && rd_cnt != IDX_MAX) rd_cnt <= rd_cnt + 1'b1;
  end

  spectrum_dpram #(
    .ADDR_W (ADDR_BITS + 1),
    .DATA_W (DATA_BITS)
  ) u_ram (
    .pix_clk (pix_clk),
    .we      (accept),
    .waddr   ({wr_bank, wr_idx}),
    .wdata   (bus.fft_mag),
    .raddr   ({~wr_bank, rd_cnt}),
    .rdata   (ram_q)
  );

  assign scaled = ram_q >> SCALE_SHIFT;

  // Output stage: disp_valid is delayed to line up with the RAM read, so the
  // stale word read just before the first swap is never shown.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      vld_pipe <= '0;
      data_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], disp_valid};
      data_q   <= vld_pipe[0] ? ((scaled > CLAMP) ? CLAMP : scaled) : '0;
    end
  end

  assign bus.fft_ready     = rdy_q;
  assign bus.fft_point_cnt = rd_cnt;
  assign bus.fft_data      = data_q;
  assign bus.frame_swap    = swap_q;
  assign bus.frame_err     = err_q;
endmodule

// File: tb/tb_spectrum_buf_ctrl.sv
// Scoreboard bench: dut0 (SCALE_SHIFT=0) and dut1 (SCALE_SHIFT=2) share one stimulus.
module tb_spectrum_buf_ctrl;
  import spectrum_buf_ctrl_pkg::*;

  logic pix_clk = 1'b0;
  logic rst     = 1'b1;
  logic probe   = 1'b0;
  always #5 pix_clk = ~pix_clk;

  spectrum_buf_ctrl_if if0 ();
  spectrum_buf_ctrl_if if1 ();

  assign if1.fft_valid      = if0.fft_valid;
  assign if1.fft_last       = if0.fft_last;
  assign if1.fft_mag        = if0.fft_mag;
  assign if1.vs_in          = if0.vs_in;
  assign if1.data_req       = if0.data_req;
  assign if1.fft_point_done = if0.fft_point_done;

  spectrum_buf_ctrl #(.SCALE_SHIFT(0)) dut0 (.pix_clk(pix_clk), .rst(rst), .bus(if0.slave));
  spectrum_buf_ctrl #(.SCALE_SHIFT(2)) dut1 (.pix_clk(pix_clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    string       name;
    logic [7:0]  cnt;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy;
  } probe_t;

  localparam int EV_SWAP = 0;
  localparam int EV_ERR  = 1;

  probe_t pq[$];
  int     evq[$];
  int     n_checks = 0;
  int     n_errors = 0;

  // Monitor: pops expected probes and expected swap/err pulses as the DUTs present them.
  probe_t p;
  int     ev;
  always @(negedge pix_clk) begin
    if (probe) begin
      n_checks++;
      if (pq.size() == 0) begin
        n_errors++;
        $display("FAIL probe_underflow: no expected entry queued");
      end else begin
        p = pq.pop_front();
        if (if0.fft_point_cnt !== p.cnt || if0.fft_data !== p.d0 ||
            if1.fft_data !== p.d1 || if0.fft_ready !== p.rdy || if1.fft_ready !== p.rdy ||
            if1.fft_point_cnt !== p.cnt) begin
          n_errors++;
          $display("FAIL %s: got cnt=%0d d0=%0d d1=%0d rdy=%b/%b, want cnt=%0d d0=%0d d1=%0d rdy=%b",
                   p.name, if0.fft_point_cnt, if0.fft_data, if1.fft_data, if0.fft_ready,
                   if1.fft_ready, p.cnt, p.d0, p.d1, p.rdy);
        end
      end
    end
    if (if0.frame_swap || if1.frame_swap) begin
      n_checks++;
      if (evq.size() == 0) begin
        n_errors++;
        $display("FAIL frame_swap: got unexpected pulse (%b/%b), want none", if0.frame_swap, if1.frame_swap);
      end else begin
        ev = evq.pop_front();
        if (ev != EV_SWAP || !(if0.frame_swap && if1.frame_swap)) begin
          n_errors++;
          $display("FAIL frame_swap: got swap=%b/%b, want event kind %0d", if0.frame_swap, if1.frame_swap, ev);
        end
      end
    end
    if (if0.frame_err || if1.frame_err) begin
      n_checks++;
      if (evq.size() == 0) begin
        n_errors++;
        $display("FAIL frame_err: got unexpected pulse (%b/%b), want none", if0.frame_err, if1.frame_err);
      end else begin
        ev = evq.pop_front();
        if (ev != EV_ERR || !(if0.frame_err && if1.frame_err)) begin
          n_errors++;
          $display("FAIL frame_err: got err=%b/%b, want event kind %0d", if0.frame_err, if1.frame_err, ev);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pix_clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int c, input int d0, input int d1, input bit r, input int wt);
    probe_t e;
    tick(wt);
    e.name = nm;
    e.cnt  = 8'(c);
    e.d0   = 32'(d0);
    e.d1   = 32'(d1);
    e.rdy  = r;
    pq.push_back(e);
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  task automatic req(input int n);
    if0.data_req = 1'b1;
    tick(n);
    if0.data_req = 1'b0;
  endtask

  task automatic vsync();
    if0.vs_in = 1'b1;
    tick(1);
    if0.vs_in = 1'b0;
  endtask

  function automatic int val(input int mode, input int i);
    case (mode)
      1:       return i + 1000;
      2:       return (i == 0) ? 4000 : (i == 1) ? 400 : 2 * i;
      3:       return 255 - i;
      4:       return i + 500;
      default: return i;
    endcase
  endfunction

  // Streams n samples; last_at < 0 means fft_last is never set.
  task automatic send(input int n, input int last_at, input int mode);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!if0.fft_ready && w < 20) begin
        tick(1);
        w++;
      end
      if (!if0.fft_ready) begin
        n_checks++;
        n_errors++;
        $display("FAIL ready_timeout: got fft_ready=0 at sample %0d, want 1", i);
      end
      if0.fft_valid = 1'b1;
      if0.fft_mag   = 32'(val(mode, i));
      if0.fft_last  = (i == last_at);
      tick(1);
    end
    if0.fft_valid = 1'b0;
    if0.fft_last  = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    if0.fft_valid = 1'b0; if0.fft_last = 1'b0; if0.fft_mag = '0;
    if0.vs_in = 1'b0; if0.data_req = 1'b0; if0.fft_point_done = 1'b0;

    // Reset values, then ready rises
    chk("reset", 0, 0, 0, 1'b0, 3);
    rst = 1'b0;
    chk("post_reset_ready", 0, 0, 0, 1'b1, 1);

    // Pre-swap blanking
    req(5);
    chk("blank", 5, 0, 0, 1'b1, 2);

    // Clean frame value=index, then swap
    send(256, 255, 0);
    chk("full_ready_low", 5, 0, 0, 1'b0, 1);
    evq.push_back(EV_SWAP);
    vsync();
    chk("swap_bin0", 0, 0, 0, 1'b1, 3);
    req(10);
    chk("bin10", 10, 10, 2, 1'b1, 2);

    // Handshake corners
    req(3);
    if0.data_req = 1'b1; if0.fft_point_done = 1'b1;
    tick(1);
    if0.data_req = 1'b0; if0.fft_point_done = 1'b0;
    chk("req_done_same", 0, 0, 0, 1'b1, 2);
    req(300);
    chk("saturate", 255, 255, 63, 1'b1, 2);

    // Malformed frames: early last, then missing last
    evq.push_back(EV_ERR);
    send(101, 100, 1);
    chk("early_last", 255, 255, 63, 1'b1, 2);
    evq.push_back(EV_ERR);
    send(256, -1, 1);
    chk("missing_last", 255, 255, 63, 1'b1, 2);

    // Vsync in FILL: no swap, old bank stays on screen
    vsync();
    req(20);
    chk("vs_in_fill", 20, 20, 5, 1'b1, 2);

    // Clamp and scale frame
    send(256, 255, 2);
    chk("clamp_full", 20, 20, 5, 1'b0, 1);
    evq.push_back(EV_SWAP);
    vsync();
    chk("clamp_4000", 0, 719, 719, 1'b1, 3);
    req(1);
    chk("scale_400", 1, 400, 100, 1'b1, 2);
    req(9);
    chk("clamp_bin10", 10, 20, 5, 1'b1, 2);

    // Reset mid-frame
    send(128, -1, 4);
    rst = 1'b1;
    chk("mid_reset", 0, 0, 0, 1'b0, 2);
    rst = 1'b0;
    chk("after_mid_reset", 0, 0, 0, 1'b1, 2);
    send(256, 255, 3);
    evq.push_back(EV_SWAP);
    if0.vs_in = 1'b1; if0.data_req = 1'b1;
    tick(1);
    if0.vs_in = 1'b0; if0.data_req = 1'b0;
    chk("swap_with_req", 0, 255, 63, 1'b1, 3);
    req(3);
    chk("reset_frame_bin3", 3, 252, 63, 1'b1, 2);

    tick(5);
    n_checks++;
    if (evq.size() != 0 || pq.size() != 0) begin
      n_errors++;
      $display("FAIL pending_events: got %0d events %0d probes outstanding, want 0", evq.size(), pq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
